// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the sequential picoMIPS ALU.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package alu_seq_pkg;

    // Widest datapath the saturation helper supports.
    localparam int MAXW = 64;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_MAC    = 3'd3,
        OP_CLRACC = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

    // Width-generic clamp. It passes val through unless ovf is set. On
    // overflow it returns the most positive or most negative n-bit value,
    // chosen by neg. Callers truncate the result to their own width.
    function automatic logic [MAXW-1:0] sat_n(input logic            ovf,
                                              input logic            neg,
                                              input logic [MAXW-1:0] val,
                                              input int              n);
        logic [MAXW-1:0] lim;
        lim = '0;
        for (int i = 0; i < MAXW; i++) begin
            lim[i] = (i < n - 1);
        end
        // ~0..0111..1 has 100..0 in its low n bits, which is -2^(n-1).
        if (neg) begin
            lim = ~lim;
        end
        sat_n = ovf ? lim : val;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned N x N radix-2 shift-add multiplier core; one partial product per step.
// Latency: N step cycles after load; the step count is kept by the caller.
// Backpressure: none; the multiplier holds its state whenever step is low.
//
// Ports: load captures mcand/mplier and clears the upper half of the product.
// Each step adds mcand into the upper half when the current multiplier bit is
// set, then shifts the whole product register right. After N steps, product
// holds mcand*mplier.
module mul_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    input  logic           step,
    output logic [2*N-1:0] product
);

    logic [N-1:0] mcand_q;
    logic [N:0]   partial;

    // The multiplier bits sit in the low half and are consumed from bit 0.
    // The N+1-bit sum keeps the carry, which is shifted back in at the top.
    assign partial = {1'b0, product[2*N-1:N]} + (product[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            product <= '0;
        end else if (load) begin
            mcand_q <= mcand;
            product <= {{N{1'b0}}, mplier};
        end else if (step) begin
            product <= {partial, product[N-1:1]};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: saturating add/sub (1 cycle), Q1.(N-1) multiply and MAC (N+2 cycles).
// Latency: single-cycle ops finish 1 cycle after start; MUL/MAC finish N+2 cycles after start.
// Backpressure: start is ignored while busy; there is no queueing and operands are not resampled.
//
// Ports: clk, reset (async, active-high); start/op/a/b request and operands,
// sampled only when idle; busy is high during ITER/FIN; done is a one-cycle
// completion pulse; result and flags {V,N,Z,C} hold until the next completion.
module alu_seq #(
    parameter int N    = 8,
    parameter int FRAC = N - 1,
    parameter bit SAT  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);
    import alu_seq_pkg::*;

    localparam int CW = $clog2(N);
    localparam int HW = N - FRAC + 1;   // product bits that must agree in sign

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            neg_q;
    logic            mac_q;
    logic [N-1:0]    acc;
    logic            is_mul_op;
    logic            mul_load;
    logic [N-1:0]    mag_a, mag_b;
    logic [2*N-1:0]  product;

    // Single-cycle datapath
    logic [N-1:0]    bx;
    logic [N:0]      sum_ext;
    logic            add_v;
    logic [N-1:0]    sc_res;
    logic [3:0]      sc_flags;

    // Multi-cycle finish datapath
    logic [2*N-1:0]  p_s;
    logic [HW-1:0]   p_hi;
    logic            mul_v;
    logic [N-1:0]    m_res;
    logic [N-1:0]    acc_sum;
    logic            acc_v;
    logic [N-1:0]    fin_res;
    logic            fin_v;
    logic [3:0]      fin_flags;

    assign is_mul_op = (op == OP_MUL) || (op == OP_MAC);
    assign mul_load  = (state == IDLE) && start && is_mul_op;
    assign busy      = (state != IDLE);

    // The core multiplies magnitudes. |-2^(N-1)| = 2^(N-1) still fits in N
    // unsigned bits, so the most negative operand needs no special case.
    assign mag_a = a[N-1] ? -a : a;
    assign mag_b = b[N-1] ? -b : b;

    mul_seq #(.N(N)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .mcand   (mag_a),
        .mplier  (mag_b),
        .step    (state == ITER),
        .product (product)
    );

    always_comb begin
        bx       = (op == OP_SUB) ? ~b : b;
        sum_ext  = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, (op == OP_SUB)};
        add_v    = (a[N-1] == bx[N-1]) && (sum_ext[N-1] != a[N-1]);
        sc_res   = '0;
        sc_flags = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_res   = N'(sat_n(add_v && SAT, a[N-1], MAXW'(sum_ext[N-1:0]), N));
                sc_flags = {add_v, sc_res[N-1], (sc_res == '0), sum_ext[N]};
            end
            OP_CLRACC: sc_flags = 4'b0010;
            default:   sc_flags = 4'b0000;   // reserved codes: zero result, zero flags
        endcase
    end

    always_comb begin
        p_s     = neg_q ? -product : product;
        // The shift followed by truncation is a floor slice of the signed
        // product. It rounds toward minus infinity, never toward zero.
        p_hi    = HW'(p_s >> (FRAC + N - 1));
        mul_v   = !((&p_hi) || !(|p_hi));
        m_res   = N'(sat_n(mul_v && SAT, p_s[2*N-1], MAXW'(N'(p_s >> FRAC)), N));
        acc_sum = acc + m_res;
        acc_v   = (acc[N-1] == m_res[N-1]) && (acc_sum[N-1] != acc[N-1]);
        fin_res = mac_q ? N'(sat_n(acc_v && SAT, acc[N-1], MAXW'(acc_sum), N)) : m_res;
        fin_v   = mul_v || (mac_q && acc_v);
        fin_flags = {fin_v, fin_res[N-1], (fin_res == '0), 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && is_mul_op) state_nxt = ITER;
            ITER:    if (cnt == '0)          state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            neg_q  <= 1'b0;
            mac_q  <= 1'b0;
            acc    <= '0;
            result <= '0;
            flags  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul_op) begin
                            cnt   <= CW'(N - 1);
                            neg_q <= a[N-1] ^ b[N-1];
                            mac_q <= (op == OP_MAC);
                        end else begin
                            result <= sc_res;
                            flags  <= sc_flags;
                            done   <= 1'b1;
                            if (op == OP_CLRACC) begin
                                acc <= '0;
                            end
                        end
                    end
                end
                ITER: cnt <= cnt - CW'(1);
                FIN: begin
                    result <= fin_res;
                    flags  <= fin_flags;
                    done   <= 1'b1;
                    if (mac_q) begin
                        acc <= fin_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, start16;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] a16, b16;
    logic        busy, done, busy_w, done_w, busy16, done16;
    logic [7:0]  result, result_w;
    logic [15:0] result16;
    logic [3:0]  flags, flags_w, flags16;

    int n_checks = 0;
    int n_errs   = 0;
    int lat, bcyc, pulses;

    always #5 clk = ~clk;

    alu_seq #(.N(8), .FRAC(7), .SAT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags));

    alu_seq #(.N(8), .FRAC(7), .SAT(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_w), .done(done_w), .result(result_w), .flags(flags_w));

    alu_seq #(.N(16), .FRAC(15), .SAT(1'b1)) u_w16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .flags(flags16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the cycle after the accepting edge.
    task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done. The cycle budget
    // bounds the wait.
    task automatic wait8(input int lat0, output int l, output int bc);
        l  = lat0;
        bc = 0;
        while (done !== 1'b1 && l < 40) begin
            if (busy) bc++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_sc8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input logic [3:0] ef, input string tag);
        issue8(o, x, y);
        check({tag, "_done"},  done,   1'b1);
        check({tag, "_res"},   result, er);
        check({tag, "_flags"}, flags,  ef);
    endtask

    task automatic run_mul8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] er, input logic [3:0] ef, input string tag);
        issue8(o, x, y);
        check({tag, "_busy"}, busy, 1'b1);
        wait8(1, lat, bcyc);
        check({tag, "_lat"},   lat,    10);
        check({tag, "_bcyc"},  bcyc,   9);
        check({tag, "_res"},   result, er);
        check({tag, "_flags"}, flags,  ef);
        @(negedge clk);
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start16 = 1'b0; op = 3'd0;
        a = '0; b = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   busy,     1'b0);
        check("rst_done",   done,     1'b0);
        check("rst_res",    result,   8'h00);
        check("rst_flags",  flags,    4'h0);
        check("rst_busy_w", busy_w,   1'b0);
        check("rst_res16",  result16, 16'h0000);
        reset = 1'b0;

        run_sc8(OP_ADD, 8'h70, 8'h20, 8'h7F, 4'h8, "add_sat");
        check("add_wrap_done",  done_w,   1'b1);
        check("add_wrap_res",   result_w, 8'h90);
        check("add_wrap_flags", flags_w,  4'hC);
        run_sc8(OP_SUB, 8'h00, 8'h01, 8'hFF, 4'h4, "sub");

        // Reset four cycles into a multiply.
        issue8(OP_MUL, 8'h40, 8'h40);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy",  busy,   1'b0);
        check("midrst_res",   result, 8'h00);
        check("midrst_flags", flags,  4'h0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_nodone", pulses, 0);
        run_sc8(OP_ADD, 8'h01, 8'h02, 8'h03, 4'h0, "add_post_rst");

        run_mul8(OP_MUL, 8'h40, 8'h40, 8'h20, 4'h0, "mul_pos");
        run_mul8(OP_MUL, 8'hC0, 8'h40, 8'hE0, 4'h4, "mul_neg");
        run_mul8(OP_MUL, 8'hFF, 8'h01, 8'hFF, 4'h4, "mul_floor");
        run_mul8(OP_MUL, 8'h80, 8'h80, 8'h7F, 4'h8, "mul_ovf");

        run_sc8(OP_CLRACC, 8'h12, 8'h34, 8'h00, 4'h2, "clracc");
        run_mul8(OP_MAC, 8'h40, 8'h40, 8'h20, 4'h0, "mac1");
        run_mul8(OP_MAC, 8'h40, 8'h40, 8'h40, 4'h0, "mac2");
        run_mul8(OP_MAC, 8'h7F, 8'h7F, 8'h7F, 4'h8, "mac_sat");

        // A start raised during ITER must be ignored.
        issue8(OP_MUL, 8'h40, 8'hC0);
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait8(3, lat, bcyc);
        check("ign_lat",   lat,    10);
        check("ign_res",   result, 8'hE0);
        check("ign_flags", flags,  4'h4);
        // A start raised in the done cycle must be accepted.
        start = 1'b1; op = OP_ADD; a = 8'h05; b = 8'h06;
        @(negedge clk);
        start = 1'b0;
        check("bb_done",  done,   1'b1);
        check("bb_res",   result, 8'h0B);
        check("bb_flags", flags,  4'h0);

        // 16-bit variant
        @(negedge clk);
        start16 = 1'b1; op = OP_MUL; a16 = 16'h4000; b16 = 16'h4000;
        @(negedge clk);
        start16 = 1'b0;
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("w16_lat",   lat,      18);
        check("w16_res",   result16, 16'h2000);
        check("w16_flags", flags16,  4'h0);
        @(negedge clk);
        start16 = 1'b1; op = 3'd7; a16 = 16'h1234; b16 = 16'h5678;
        @(negedge clk);
        start16 = 1'b0;
        check("w16_rsv_done",  done16,   1'b1);
        check("w16_rsv_res",   result16, 16'h0000);
        check("w16_rsv_flags", flags16,  4'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the picoMIPS single-cycle ALU. It provides saturating add and subtract, plus a Q1.(N-1) fractional multiply and multiply-accumulate computed over N cycles by a shift-add engine. A start/busy/done handshake sits between it and the picoMIPS controller, and it reports V,N,Z,C flags. The datapath width is generic, so the same block serves the 8-bit core and wider variants.

## Interface
Parameters:
- N, 8, operand/result width in bits (≥4)
- FRAC, N-1, fractional bits; product slice is p[FRAC+N-1:FRAC]
- SAT, 1, 1 = saturate on overflow, 0 = wrap (V still reported)

Ports:
- clk  in  1  clock; everything rising-edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  request; sampled only when busy=0
- op  in  3  operation code (alu_seq_pkg)
- a, b  in  N  signed operands, sampled with start
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle completion pulse
- result  out  N  last completed result, held until next completion
- flags  out  4  {V,N,Z,C} of last completed op, held likewise

## Operation
- Ops: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_MAC=3, OP_CLRACC=4; codes 5–7 reserved → complete as single-cycle, result=0, flags=0.
- ADD/SUB:
  - Computed as a + b or a + ~b + 1.
  - C = carry-out of that N-bit sum.
  - V = signed overflow.
  - If SAT, overflow clamps to 2^(N-1)-1 / -2^(N-1) by sign of a.
- MUL:
  - p = exact 2N-bit two's-complement product.
  - Result = p[FRAC+N-1:FRAC]; truncation equals arithmetic right shift (floor), never toward zero.
  - V = 1 when p[2N-1:FRAC+N-1] is not all-equal. If SAT, clamp by sign of p.
  - C = 0.
- MAC:
  - m = MUL result with its saturation.
  - acc ← sat(acc + m).
  - result = new acc.
  - V = mul V OR add V. C = 0.
- CLRACC: acc ← 0, result = 0, flags {0,0,1,0}.
- N = result[N-1]; Z = (result==0), both computed on the final (saturated) result.
- Internal accumulator acc (N bits) is touched only by MAC/CLRACC.
- FSM:
  - IDLE: on start, ADD/SUB/CLRACC/reserved are computed and registered at that edge, with done=1 in the next cycle. MUL/MAC latch |a|, |b| and the sign → ITER.
  - ITER: N cycles of radix-2 shift-add on magnitudes; counter N-1 → 0; → FIN.
  - FIN: negate the 2N-bit product if the sign is set, slice, saturate, update acc (MAC), register outputs, pulse done → IDLE.
- busy = 1 in ITER and FIN only.
- start while busy is ignored: no queueing, operands not resampled.

## Timing
- Single-cycle ops: start accepted at edge k; result/flags/done valid in cycle k+1. Back-to-back single-cycle starts run at one op per cycle.
- MUL/MAC: start accepted at edge k; busy high from k+1 to k+N+1; done and result valid in cycle k+N+2 (latency N+2; 10 for N=8).
- done is high for exactly one cycle with busy=0. A start in the done cycle is accepted.
- Reset, asserted any time including mid-ITER:
  - State → IDLE, acc=0, result=0, flags=0, busy=0, done=0.
  - The aborted operation never produces done.
- Operands a, b and op may change freely after the accepting edge.

## Structure
- Package alu_seq_pkg:
  - op_t enum with the codes above.
  - state_t {IDLE, ITER, FIN}.
  - Function sat_n (width-generic clamp helper).
- Sub-module mul_seq:
  - Unsigned N×N radix-2 shift-add.
  - Ports: load, operands, step, product [2N-1:0].
  - Iteration counter owned by the top FSM.
- Top alu_seq holds the FSM, add/sub datapath, acc, and the output registers.

## Test plan
- Reset mid-MUL (4 cycles after start) → busy=0, done never pulses, result=0x00. The next ADD 0x01+0x02 → result 0x03, flags 0000.
- N=8 ADD 0x70+0x20 → result 0x7F, V=1, N=0, C=0. The same with SAT=0 → 0x90, V=1, N=1. SUB 0x00-0x01 → 0xFF, N=1, C=0.
- N=8 MUL:
  - 0x40×0x40 → 0x20, done exactly 10 cycles after the start edge.
  - 0xC0×0x40 → 0xE0.
  - 0xFF×0x01 → 0xFF (floor).
  - 0x80×0x80 → 0x7F, V=1.
- CLRACC, then MAC 0x40×0x40 twice → results 0x20 then 0x40. MAC 0x7F×0x7F from acc 0x40 → 0x7F with V=1.
- start pulsed during ITER with op=ADD → ignored; the MUL result is unaffected. start in the done cycle → accepted; the single-cycle result follows in the next cycle.
- N=16, FRAC=15: MUL 0x4000×0x4000 → 0x2000 with latency 18; reserved op 7 → result 0, flags 0, done next cycle.
